// File: rtl/fetch_decoder.sv
// Instruction fetch/decode sequencer: fetches one 16-bit word per pc_strobe and decodes it into PC control.
// Latency: strobe sampled at edge N, mem_ready at N+1 -> decoded outputs and instr_valid after edge N+2.
// Backpressure: mem_req is held until mem_ready; strobes arriving while busy collapse into one pending fetch (newest pc wins).
//
// Ports: clk/rst (async active-high); pc/pc_strobe from the counter block; zero_flag from the datapath;
//        mem_addr/mem_req/mem_rdata/mem_ready to instruction memory; step/jump/jump_target/halt decoded
//        PC control; instr_valid decode strobe; busy (not IDLE); err (illegal opcode or fetch timeout, sticky).
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch after TIMEOUT_CYCLES cycles without mem_ready.
module fetch_decoder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pc,
    input  logic        pc_strobe,
    input  logic        zero_flag,
    output logic [7:0]  mem_addr,
    output logic        mem_req,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [7:0]  step,
    output logic        jump,
    output logic [7:0]  jump_target,
    output logic        halt,
    output logic        instr_valid,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'h2;
    localparam logic [3:0] OP_SKIP = 4'h3;
    localparam logic [3:0] OP_JZ   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;

    logic [1:0] state;
    logic       pending;
    logic [7:0] pending_pc;
    logic [3:0] instr_op;
    logic [7:0] instr_imm;

    // Bits 11:8 of the instruction word carry nothing for this decoder.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[11:8];

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            pending_pc  <= 8'h00;
            instr_op    <= 4'h0;
            instr_imm   <= 8'h00;
            mem_addr    <= 8'h00;
            mem_req     <= 1'b0;
            step        <= 8'h00;
            jump        <= 1'b0;
            jump_target <= 8'h00;
            halt        <= 1'b0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            instr_valid <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (halt) begin
                        // A halted core never fetches again; drop anything left over.
                        pending <= 1'b0;
                    end else if (pc_strobe || pending) begin
                        // A fresh strobe is newer than anything recorded while busy.
                        mem_addr <= pc_strobe ? pc : pending_pc;
                        mem_req  <= 1'b1;
                        pending  <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (pc_strobe) begin
                        pending    <= 1'b1;
                        pending_pc <= pc;
                    end
                    if (mem_ready) begin
                        instr_op  <= mem_rdata[15:12];
                        instr_imm <= mem_rdata[7:0];
                        mem_req   <= 1'b0;
                        state     <= S_DECODE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        // Give up on memory: retire the slot as a NOP and flag it.
                        instr_op  <= OP_NOP;
                        instr_imm <= 8'h00;
                        mem_req   <= 1'b0;
                        err       <= 1'b1;
                        state     <= S_DECODE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    if (pc_strobe) begin
                        pending    <= 1'b1;
                        pending_pc <= pc;
                    end
                    instr_valid <= 1'b1;
                    state       <= S_IDLE;
                    case (instr_op)
                        OP_NOP: begin
                            step <= 8'd1;
                            jump <= 1'b0;
                        end
                        OP_JMP: begin
                            step        <= 8'd0;
                            jump        <= 1'b1;
                            jump_target <= instr_imm;
                        end
                        OP_HALT: begin
                            step <= 8'd0;
                            jump <= 1'b0;
                            halt <= 1'b1;
                        end
                        OP_SKIP: begin
                            step <= 8'd2;
                            jump <= 1'b0;
                        end
                        OP_JZ: begin
                            step        <= zero_flag ? 8'd0 : 8'd1;
                            jump        <= zero_flag;
                            jump_target <= instr_imm;
                        end
                        OP_ADDI: begin
                            step <= instr_imm;
                            jump <= 1'b0;
                        end
                        default: begin
                            step <= 8'd1;
                            jump <= 1'b0;
                            err  <= 1'b1;
                        end
                    endcase
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_decoder.md
FETCH_DECODER -- requirements
Module: fetch_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waited for mem_ready (used only with FETCH_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc  input  8  current program-counter value from the counter block.
REQ-005 SHALL have port pc_strobe  input  1  one-cycle pulse: pc has a new value to fetch.
REQ-006 SHALL have port zero_flag  input  1  datapath zero flag, sampled during DECODE.
REQ-007 SHALL have port mem_addr  output  8  instruction memory address, registered.
REQ-008 SHALL have port mem_req  output  1  memory read request, held until accepted.
REQ-009 SHALL have port mem_rdata  input  16  instruction word, valid when mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  memory accepts the request and presents data this cycle.
REQ-011 SHALL have ports step (output, 8) = PC increment; jump (output, 1) = load target; jump_target (output, 8) = load value.
REQ-012 SHALL have ports halt (output, 1) = stop-run request; instr_valid (output, 1) = decode strobe; busy (output, 1) = state not IDLE; err (output, 1) = illegal opcode or timeout.

Function
REQ-013 SHALL implement FSM IDLE -> FETCH -> DECODE -> IDLE.
REQ-014 IDLE: pc_strobe sampled high and halt=0 -> latch pc into mem_addr, assert mem_req, enter FETCH.
REQ-015 FETCH: mem_req held high, mem_addr stable; on edge with mem_ready=1 capture mem_rdata, drop mem_req, enter DECODE.
REQ-016 DECODE: one cycle; register step/jump/jump_target/halt/err, pulse instr_valid for exactly one cycle, return to IDLE.
REQ-017 Instruction format: opcode = rdata[15:12], imm = rdata[7:0]; rdata[11:8] ignored.
REQ-018 Opcode 0 NOP: step=1, jump=0; 1 JMP: step=0, jump=1, jump_target=imm; 2 HALT: step=0, halt=1.
REQ-019 Opcode 3 SKIP: step=2; opcode 4 JZ: jump=zero_flag, jump_target=imm, step=zero_flag?0:1; opcode 5 ADDI: step=imm (8-bit, wraps mod 256 downstream).
REQ-020 Opcodes 6-15 SHALL decode as NOP and set err sticky until rst.
REQ-021 step/jump/jump_target SHALL hold last decoded value between instr_valid pulses; jump SHALL be meaningful only with instr_valid.
REQ-022 Minimum latency: pc_strobe sampled at edge N, mem_ready high in the following cycle -> instr_valid high after edge N+2.
REQ-023 pc_strobe while busy SHALL set a pending flag and record pc; on return to IDLE with pending set, a new fetch starts the next edge using the newest recorded pc.
REQ-024 pc_strobe coincident with mem_ready SHALL complete the current fetch and set pending.
REQ-025 halt SHALL be sticky: while halt=1, pc_strobe is ignored and no fetch starts; only rst clears it.
REQ-026 mem_addr wraps naturally: pc=0xFF is fetched as 0xFF; no address arithmetic is performed internally.

Reset
REQ-027 rst high SHALL asynchronously force IDLE, mem_req=0, mem_addr=0, step=0, jump=0, jump_target=0, halt=0, instr_valid=0, busy=0, err=0, pending=0.
REQ-028 rst mid-FETCH SHALL abort the request; a mem_ready arriving after rst deassert SHALL be ignored.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN defined: FETCH counts cycles; after TIMEOUT_CYCLES cycles without mem_ready, drop mem_req, set err, decode as NOP (instr_valid pulse), return to IDLE.
REQ-030 FETCH_TIMEOUT_EN undefined: no timeout counter; FETCH waits indefinitely; err is set only by illegal opcodes.

Verification
REQ-031 pc=0x10 strobe, mem_ready immediate, rdata=0x0000 -> mem_addr=0x10, instr_valid two edges later, step=1, jump=0.
REQ-032 rdata=0x1042 -> jump=1, jump_target=0x42, step=0; then rdata=0x4055 with zero_flag=0 -> jump=0, step=1; with zero_flag=1 -> jump=1, jump_target=0x55.
REQ-033 rdata=0x2000 -> halt=1; subsequent pc_strobe produces no mem_req; rst clears halt.
REQ-034 mem_ready delayed 5 cycles, pc_strobe pc=0x21 then pc=0x22 during FETCH -> first fetch completes, next fetch address 0x22 only.
REQ-035 rdata=0xF0AB -> step=1, err=1 and remains 1 after later valid fetches.
REQ-036 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready held 0 -> mem_req drops after 8 cycles, err=1, instr_valid pulse with step=1; rst asserted mid-FETCH -> mem_req=0 immediately.
